// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_mux
// Purpose  : N-digit multiplexed 7-segment driver with tear-free frame-boundary
//            updates, anti-ghost blanking and leading-zero suppression.
//            Define SEG_BCD_EN to build the sequential binary-to-BCD front end.
// Revision : 1.0
// ============================================================================
module seg_display_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    busy,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int c_dw = 4 * NUM_DIGITS;
  localparam int c_pw = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_iw = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_pw-1:0] c_presc_max = c_pw'(REFRESH_DIV - 1);
  localparam logic [c_pw-1:0] c_blank     = c_pw'(BLANK_CYCLES);
  localparam logic [c_iw-1:0] c_idx_max   = c_iw'(NUM_DIGITS - 1);

  function automatic logic [6:0] f_seg7(input logic [3:0] v);
    case (v)
      4'h0:    f_seg7 = 7'b1000000;
      4'h1:    f_seg7 = 7'b1111001;
      4'h2:    f_seg7 = 7'b0100100;
      4'h3:    f_seg7 = 7'b0110000;
      4'h4:    f_seg7 = 7'b0011001;
      4'h5:    f_seg7 = 7'b0010010;
      4'h6:    f_seg7 = 7'b0000010;
      4'h7:    f_seg7 = 7'b1111000;
      4'h8:    f_seg7 = 7'b0000000;
      4'h9:    f_seg7 = 7'b0010000;
      4'hA:    f_seg7 = 7'b0001000;
      4'hB:    f_seg7 = 7'b0000011;
      4'hC:    f_seg7 = 7'b1000110;
      4'hD:    f_seg7 = 7'b0100001;
      4'hE:    f_seg7 = 7'b0000110;
      default: f_seg7 = 7'b0001110;
    endcase
  endfunction

  // Scan timing
  logic [c_pw-1:0] r_presc;
  logic [c_iw-1:0] r_idx;
  logic            w_slot_end;
  logic            w_frame_end;

  assign w_slot_end  = (r_presc == c_presc_max);
  assign w_frame_end = w_slot_end && (r_idx == c_idx_max);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_slot_end) begin
      r_presc <= '0;
      r_idx   <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Complete values written into pending by whichever front end is built
  logic                       w_commit;
  logic [NUM_DIGITS-1:0][3:0] w_commit_val;
  logic [NUM_DIGITS-1:0]      w_commit_dp;
  logic                       w_commit_ovf;

`ifdef SEG_BCD_EN
  function automatic logic [c_dw-1:0] f_dec_max();
    logic [c_dw-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      v = v * c_dw'(10) + c_dw'(9);
    end
    return v;
  endfunction

  localparam int              c_cw       = $clog2(c_dw);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(c_dw - 1);
  localparam logic [c_dw-1:0] c_dec_max  = f_dec_max();
  localparam logic [0:0]      c_st_idle  = 1'b0;
  localparam logic [0:0]      c_st_conv  = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [c_cw-1:0]       r_cnt;
  logic [c_dw-1:0]       r_bin;
  logic [c_dw-1:0]       r_bcd;
  logic [c_dw-1:0]       w_bcd_adj;
  logic [c_dw-1:0]       w_bcd_nxt;
  logic [NUM_DIGITS-1:0] r_conv_dp;
  logic                  r_conv_ovf;
  logic                  w_start;

  assign w_start = (r_state == c_st_idle) && load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (load) w_state_nxt = c_st_conv;
      c_st_conv: if (r_cnt == c_cnt_last) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state == c_st_conv);
  end

  // Double-dabble step: add-3 correction on every digit, then shift in the next bit
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_bcd_nxt = (w_bcd_adj << 1) | {{(c_dw-1){1'b0}}, r_bin[c_dw-1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_conv_dp  <= '0;
      r_conv_ovf <= 1'b0;
    end else if (w_start) begin
      r_cnt      <= '0;
      r_bin      <= data;
      r_bcd      <= '0;
      r_conv_dp  <= dp_in;
      r_conv_ovf <= (data > c_dec_max);
    end else if (r_state == c_st_conv) begin
      r_cnt <= r_cnt + 1'b1;
      r_bin <= r_bin << 1;
      r_bcd <= w_bcd_nxt;
    end
  end

  assign w_commit     = (r_state == c_st_conv) && (r_cnt == c_cnt_last);
  assign w_commit_val = w_bcd_nxt;
  assign w_commit_dp  = r_conv_dp;
  assign w_commit_ovf = r_conv_ovf;
`else
  assign busy         = 1'b0;
  assign w_commit     = load;
  assign w_commit_val = data;
  assign w_commit_dp  = dp_in;
  assign w_commit_ovf = 1'b0;
`endif

  // Pending collects loads; shadow only changes on the frame boundary so a frame is never torn
  logic [NUM_DIGITS-1:0][3:0] r_pend;
  logic [NUM_DIGITS-1:0][3:0] r_shadow;
  logic [NUM_DIGITS-1:0]      r_pend_dp;
  logic [NUM_DIGITS-1:0]      r_shadow_dp;
  logic                       r_pend_ovf;
  logic                       r_shadow_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_ovf   <= 1'b0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_shadow_ovf <= 1'b0;
    end else begin
      if (w_frame_end) begin
        r_shadow     <= r_pend;
        r_shadow_dp  <= r_pend_dp;
        r_shadow_ovf <= r_pend_ovf;
      end
      if (w_commit) begin
        r_pend     <= w_commit_val;
        r_pend_dp  <= w_commit_dp;
        r_pend_ovf <= w_commit_ovf;
      end
    end
  end

  // w_lz[k] = every digit from k upward is zero
  logic [NUM_DIGITS-1:0] w_lz;

  always_comb begin
    w_lz = '0;
    w_lz[NUM_DIGITS-1] = (r_shadow[NUM_DIGITS-1] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      w_lz[k] = w_lz[k+1] && (r_shadow[k] == 4'd0);
    end
  end

  logic [NUM_DIGITS-1:0] w_an;
  logic [6:0]            w_seg;
  logic                  w_dp;

  always_comb begin
    w_an = '1;
    if (enable && (r_presc >= c_blank)) w_an[r_idx] = 1'b0;
    if (r_shadow_ovf) begin
      w_seg = 7'b0111111;
      w_dp  = 1'b1;
    end else begin
      w_dp = ~r_shadow_dp[r_idx];
      if (blank_lz && (r_idx != '0) && w_lz[r_idx]) w_seg = 7'h7F;
      else                                          w_seg = f_seg7(r_shadow[r_idx]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= w_seg;
      dp  <= w_dp;
      an  <= w_an;
    end
  end

endmodule
`default_nettype wire
